act_res_packer: RTL and testbench
=================================

// Module: act_res_packer
// PURPOSE
//  Downstream stage of sigmoid_tanh_cell. Takes one 32-bit activation result per cycle (no backpressure upstream).
//  Narrows each result to 16 bits: FP32->FP16 or INT32->INT16. Packs 4 results per 64-bit beat.
//  Buffers beats in a small FIFO and presents them on an AXIS master toward the output write-back DMA.
// PARAMETERS
//  INFO_ALONG_WIDTH  2    width of along-info; bit0 = last element of row, other bits ignored
//  FIFO_DEPTH        8    beat FIFO depth (power of 2, >=4)
//  SIM_DELAY         1    register update delay for simulation
// PORTS
//  aclk                   in   1   clock
//  aresetn                in   1   asynchronous active-low reset
//  aclken                 in   1   clock enable for input/convert/pack stages only
//  act_calfmt             in   2   00 INT16, 01 INT32, 10 FP32, 11 none (inputs ignored)
//  act_cell_o_res         in   32  activation result
//  act_cell_o_info_along  in   INFO_ALONG_WIDTH  along-info; bit0 = row last
//  act_cell_o_vld         in   1   result valid
//  m_axis_data            out  64  lane k = bits[16k+15:16k]; lane0 = oldest
//  m_axis_keep            out  8   byte enables, 2 bits per valid lane
//  m_axis_last            out  1   beat holds the row-last element
//  m_axis_valid           out  1   beat valid
//  m_axis_ready           in   1   downstream ready
//  in_stall               out  1   FIFO count >= FIFO_DEPTH-2; controller uses it to gate upstream aclken
//  err_ovf                out  1   sticky: a beat was dropped because FIFO was full
//  stat_sat_cnt           out  16  saturation count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: m_axis_valid=0, m_axis_data=0, m_axis_keep=0, m_axis_last=0, in_stall=0, err_ovf=0, stat_sat_cnt=0.
//   Lane pointer=0. FIFO empty.
//  S1 convert register (only when aclken=1). Registers 16-bit value and row-last when vld=1.
//   FP32: round to nearest even into FP16.
//    |x| > 65504 after rounding -> +/-65504 (0x7BFF/0xFBFF), counted as saturation.
//    Results below the FP16 normal range flush to signed zero. NaN -> 0x7E00. Inf -> +/-65504, saturation.
//   INT32: clamp to [-32768, 32767]; clamping counts as saturation.
//   INT16: pass res[15:0].
//   calfmt=11: vld ignored.
//  S2 pack: the S1 value is written into the lane at the pointer, and the pointer increments.
//   A beat is pushed to the FIFO when lane 3 is written or row-last=1.
//   On push, keep = 2 bits per filled lane; unfilled lanes = 0x0000. last = row-last. Pointer returns to 0.
//   A row-last on lane 0 gives keep=0x03.
//  Latency: vld of the completing element in cycle T -> m_axis_valid=1 in cycle T+2 (FIFO empty, aclken=1).
//  FIFO: first-word-fall-through. Pop when m_axis_valid && m_axis_ready. Push and pop in the same cycle are allowed when full.
//   Push while full with no pop: beat dropped, err_ovf set. err_ovf clears only on reset.
//  aclken=0: S1/S2 hold; FIFO/AXIS side keeps running. m_axis_* stable while valid && !ready.
//  act_calfmt may change only when the pipeline is empty; otherwise behaviour is undefined.
//  Reset mid-operation: partial beat and FIFO contents discarded; no output until new input arrives.
// CONFIGURATION
//  ACT_RES_PACKER_SAT_CNT_EN defined:
//   stat_sat_cnt increments once per saturated element (FP overflow/Inf or INT clamp).
//   It sticks at 0xFFFF and is cleared only by reset.
//  Not defined: stat_sat_cnt is tied to 0 and no counter logic is built.
// TESTING
//  FP32 1.0,-2.5,65520.0,1e-9 (last on 4th), ready=1
//   -> one beat data=0x0000_7BFF_C100_3C00, keep=0xFF, last=1; sat_cnt=1.
//  INT32 40,-40000,32767 with last on 3rd
//   -> data lanes 0x0028,0x8000,0x7FFF,0x0000; keep=0x3F, last=1.
//  INT16 stream of 40 elements, no last, m_axis_ready=0
//   -> in_stall rises at count 6; after FIFO full, err_ovf=1; 8 beats drain intact when ready=1.
//  Single element with last=1 (FP32 0.2)
//   -> data lane0=0x3266, keep=0x03, last=1, valid 2 cycles after vld.
//  aclken=0 for 3 cycles mid-beat plus reset asserted mid-beat
//   -> no lane loss while aclken=0; after reset all outputs 0, old partial beat never emitted.

Source files
------------

// File: rtl/act_res_packer.sv
// Narrows 32-bit activation results to 16 bits, packs four per 64-bit beat and
// streams beats out over AXIS through a FWFT FIFO. Optional macro: ACT_RES_PACKER_SAT_CNT_EN.
module act_res_packer #(
  parameter int INFO_ALONG_WIDTH = 2,
  parameter int FIFO_DEPTH       = 8,
  parameter int SIM_DELAY        = 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        aclken,
  input  logic [1:0]                  act_calfmt,
  input  logic [31:0]                 act_cell_o_res,
  input  logic [INFO_ALONG_WIDTH-1:0] act_cell_o_info_along,
  input  logic                        act_cell_o_vld,
  output logic [63:0]                 m_axis_data,
  output logic [7:0]                  m_axis_keep,
  output logic                        m_axis_last,
  output logic                        m_axis_valid,
  input  logic                        m_axis_ready,
  output logic                        in_stall,
  output logic                        err_ovf,
  output logic [15:0]                 stat_sat_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    FMT_INT16 = 2'b00,
    FMT_INT32 = 2'b01,
    FMT_FP32  = 2'b10,
    FMT_NONE  = 2'b11
  } calfmt_e;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  // SIM_DELAY is kept for drop-in compatibility; registers here update without delay.
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SIM_DELAY < 0) begin : g_param_check
    $error("act_res_packer: FIFO_DEPTH must be a power of 2 >= 4 and SIM_DELAY >= 0");
  end

  if (INFO_ALONG_WIDTH > 1) begin : g_info_unused
    logic unused_info;
    assign unused_info = ^act_cell_o_info_along[INFO_ALONG_WIDTH-1:1];
  end

  calfmt_e fmt;
  logic    in_accept;

  assign fmt       = calfmt_e'(act_calfmt);
  assign in_accept = act_cell_o_vld && (fmt != FMT_NONE);

  // FP32 -> FP16 round-to-nearest-even. The 5-bit exponent rebias wraps mod 32,
  // which is exact inside the representable window [112, 142].
  logic        fp_sign;
  logic [7:0]  fp_exp;
  logic [22:0] fp_man;
  logic [4:0]  fp_exp_h;
  logic        fp_round_up;
  logic [15:0] fp_rounded;

  assign fp_sign     = act_cell_o_res[31];
  assign fp_exp      = act_cell_o_res[30:23];
  assign fp_man      = act_cell_o_res[22:0];
  assign fp_exp_h    = fp_exp[4:0] - 5'd16;
  assign fp_round_up = fp_man[12] & ((|fp_man[11:0]) | fp_man[13]);
  assign fp_rounded  = {1'b0, fp_exp_h, fp_man[22:13]} + 16'(fp_round_up);

  logic [15:0] cvt_val;
  logic        cvt_sat;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    cvt_val = '0;
    cvt_sat = 1'b0;
    case (fmt)
      FMT_INT16: cvt_val = act_cell_o_res[15:0];
      FMT_INT32: begin
        if ($signed(act_cell_o_res) > 32'sd32767) begin
          cvt_val = 16'h7FFF;
          cvt_sat = 1'b1;
        end else if ($signed(act_cell_o_res) < -32'sd32768) begin
          cvt_val = 16'h8000;
          cvt_sat = 1'b1;
        end else begin
          cvt_val = act_cell_o_res[15:0];
        end
      end
      FMT_FP32: begin
        if (fp_exp == 8'hFF && fp_man != '0) begin
          cvt_val = 16'h7E00;
        end else if (fp_exp == 8'hFF || fp_exp > 8'd142) begin
          cvt_val = {fp_sign, 15'h7BFF};
          cvt_sat = 1'b1;
        end else if (fp_exp < 8'd112) begin
          cvt_val = {fp_sign, 15'h0000};
        end else if (fp_rounded[14:10] == 5'h1F) begin
          cvt_val = {fp_sign, 15'h7BFF};
          cvt_sat = 1'b1;
        end else if (fp_rounded[14:10] == 5'h00) begin
          cvt_val = {fp_sign, 15'h0000};
        end else begin
          cvt_val = {fp_sign, fp_rounded[14:0]};
        end
      end
      default: ;
    endcase
  end

  logic        s1_vld;
  logic [15:0] s1_data;
  logic        s1_last;

  // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
      s1_last <= 1'b0;
    end else if (aclken) begin
      s1_vld <= in_accept;
      if (in_accept) begin
        s1_data <= cvt_val;
        s1_last <= act_cell_o_info_along[0];
      end
    end
  end

  logic [15:0] lane_q [4];
  logic [1:0]  lane_ptr;
  logic        pack_push;
  beat_t       pack_beat;

  assign pack_push = aclken && s1_vld && (lane_ptr == 2'd3 || s1_last);

  always_comb begin
    pack_beat      = '0;
    pack_beat.last = s1_last;
    for (int k = 0; k < 4; k++) begin
      if (2'(k) < lane_ptr) begin
        pack_beat.data[16*k +: 16] = lane_q[k];
        pack_beat.keep[2*k +: 2]   = 2'b11;
      end else if (2'(k) == lane_ptr) begin
        pack_beat.data[16*k +: 16] = s1_data;
        pack_beat.keep[2*k +: 2]   = 2'b11;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lane_ptr <= '0;
      for (int k = 0; k < 4; k++) lane_q[k] <= '0;
    end else if (aclken && s1_vld) begin
      if (pack_push) begin
        lane_ptr <= '0;
      end else begin
        lane_q[lane_ptr] <= s1_data;
        lane_ptr         <= lane_ptr + 2'd1;
      end
    end
  end

  beat_t            fifo_mem [FIFO_DEPTH];
  beat_t            head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             pop;
  logic             wr_en;

  assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
  assign pop       = m_axis_valid && m_axis_ready;
  assign wr_en     = pack_push && (!fifo_full || pop);

  // NOTE: the storage array has no reset; only pointers and count define what is valid.
  always_ff @(posedge aclk) begin
    if (wr_en) fifo_mem[wr_ptr] <= pack_beat;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      if (pack_push && fifo_full && !pop) err_ovf <= 1'b1;
    end
  end

  assign head         = fifo_mem[rd_ptr];
  assign m_axis_valid = (count != '0);
  assign m_axis_data  = m_axis_valid ? head.data : '0;
  assign m_axis_keep  = m_axis_valid ? head.keep : '0;
  assign m_axis_last  = m_axis_valid ? head.last : 1'b0;
  assign in_stall     = (count >= CNT_W'(FIFO_DEPTH - 2));

`ifdef ACT_RES_PACKER_SAT_CNT_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sat_cnt_q <= '0;
    end else if (aclken && in_accept && cvt_sat && sat_cnt_q != 16'hFFFF) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign stat_sat_cnt = sat_cnt_q;
`else
  logic unused_sat;
  assign unused_sat   = cvt_sat;
  assign stat_sat_cnt = '0;
`endif

endmodule

// File: tb/tb_act_res_packer.sv
// Directed self-checking bench for act_res_packer: conversion, packing, latency,
// FIFO overflow/stall, clock-enable hold and mid-beat reset.
module tb_act_res_packer;

  logic        aclk;
  logic        aresetn;
  logic        aclken;
  logic [1:0]  act_calfmt;
  logic [31:0] act_cell_o_res;
  logic [1:0]  act_cell_o_info_along;
  logic        act_cell_o_vld;
  logic [63:0] m_axis_data;
  logic [7:0]  m_axis_keep;
  logic        m_axis_last;
  logic        m_axis_valid;
  logic        m_axis_ready;
  logic        in_stall;
  logic        err_ovf;
  logic [15:0] stat_sat_cnt;

  int checks;
  int failures;

`ifdef ACT_RES_PACKER_SAT_CNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  act_res_packer dut (
    .aclk                  (aclk),
    .aresetn               (aresetn),
    .aclken                (aclken),
    .act_calfmt            (act_calfmt),
    .act_cell_o_res        (act_cell_o_res),
    .act_cell_o_info_along (act_cell_o_info_along),
    .act_cell_o_vld        (act_cell_o_vld),
    .m_axis_data           (m_axis_data),
    .m_axis_keep           (m_axis_keep),
    .m_axis_last           (m_axis_last),
    .m_axis_valid          (m_axis_valid),
    .m_axis_ready          (m_axis_ready),
    .in_stall              (in_stall),
    .err_ovf               (err_ovf),
    .stat_sat_cnt          (stat_sat_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic put(input logic [31:0] res, input logic last);
    act_cell_o_res        = res;
    act_cell_o_info_along = {1'b0, last};
    act_cell_o_vld        = 1'b1;
    @(negedge aclk);
  endtask

  task automatic idle(input int n);
    act_cell_o_vld        = 1'b0;
    act_cell_o_res        = '0;
    act_cell_o_info_along = '0;
    repeat (n) @(negedge aclk);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (m_axis_valid) ok = 1'b1;
      else @(negedge aclk);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({m_axis_valid, m_axis_data, m_axis_keep, m_axis_last, in_stall, err_ovf, stat_sat_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b data=%h keep=%h last=%b stall=%b ovf=%b sat=%h exp all zero",
               m_axis_valid, m_axis_data, m_axis_keep, m_axis_last, in_stall, err_ovf, stat_sat_cnt);
    end
  endtask

  task automatic test_fp32;
    bit ok;
    act_calfmt = 2'b10;
    m_axis_ready = 1'b1;
    put(32'h3F80_0000, 1'b0);
    put(32'hC020_0000, 1'b0);
    put(32'h477F_F000, 1'b0);
    put(32'h3089_705F, 1'b1);
    idle(1);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL fp32_timeout got valid=0 exp valid=1");
    end else begin
      checks++;
      if ({m_axis_data, m_axis_keep, m_axis_last} !== {64'h0000_7BFF_C100_3C00, 8'hFF, 1'b1}) begin
        failures++;
        $display("FAIL fp32_beat got data=%h keep=%h last=%b exp data=00007bffc1003c00 keep=ff last=1",
                 m_axis_data, m_axis_keep, m_axis_last);
      end
    end
    @(negedge aclk);
    checks++;
    if (stat_sat_cnt !== (SAT_EN ? 16'd1 : 16'd0)) begin
      failures++;
      $display("FAIL fp32_sat_cnt got=%0d exp=%0d", stat_sat_cnt, SAT_EN ? 1 : 0);
    end
  endtask

  task automatic test_int32;
    bit ok;
    act_calfmt = 2'b01;
    put(32'd40, 1'b0);
    put(32'hFFFF_63C0, 1'b0);
    put(32'd32767, 1'b1);
    idle(1);
    wait_valid(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL int32_timeout got valid=0 exp valid=1");
    end else begin
      checks++;
      if ({m_axis_data, m_axis_keep, m_axis_last} !== {64'h0000_7FFF_8000_0028, 8'h3F, 1'b1}) begin
        failures++;
        $display("FAIL int32_beat got data=%h keep=%h last=%b exp data=00007fff80000028 keep=3f last=1",
                 m_axis_data, m_axis_keep, m_axis_last);
      end
    end
    @(negedge aclk);
    checks++;
    if (stat_sat_cnt !== (SAT_EN ? 16'd2 : 16'd0)) begin
      failures++;
      $display("FAIL int32_sat_cnt got=%0d exp=%0d", stat_sat_cnt, SAT_EN ? 2 : 0);
    end
  endtask

  task automatic test_single_latency;
    act_calfmt = 2'b10;
    put(32'h3E4C_CCCD, 1'b1);
    idle(0);
    act_cell_o_vld = 1'b0;
    checks++;
    if (m_axis_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_early got valid=%b exp=0", m_axis_valid);
    end
    @(negedge aclk);
    checks++;
    if ({m_axis_valid, m_axis_data, m_axis_keep, m_axis_last} !== {1'b1, 64'h0000_0000_0000_3266, 8'h03, 1'b1}) begin
      failures++;
      $display("FAIL lat_beat got valid=%b data=%h keep=%h last=%b exp valid=1 data=3266 keep=03 last=1",
               m_axis_valid, m_axis_data, m_axis_keep, m_axis_last);
    end
    @(negedge aclk);
    checks++;
    if (m_axis_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_popped got valid=%b exp=0", m_axis_valid);
    end
  endtask

  task automatic test_fmt_none;
    act_calfmt = 2'b11;
    put(32'h0000_1111, 1'b0);
    put(32'h0000_2222, 1'b1);
    idle(5);
    checks++;
    if (m_axis_valid !== 1'b0) begin
      failures++;
      $display("FAIL fmt_none got valid=%b exp=0", m_axis_valid);
    end
  endtask

  task automatic test_stall_overflow;
    bit ok;
    logic [63:0] exp_data;
    act_calfmt   = 2'b00;
    m_axis_ready = 1'b0;
    for (int i = 0; i < 20; i++) put(32'hABCD_0000 | 32'(i), 1'b0);
    idle(3);
    checks++;
    if ({in_stall, err_ovf} !== 2'b00) begin
      failures++;
      $display("FAIL stall_at5 got stall=%b ovf=%b exp stall=0 ovf=0", in_stall, err_ovf);
    end
    for (int i = 20; i < 24; i++) put(32'hABCD_0000 | 32'(i), 1'b0);
    idle(3);
    checks++;
    if ({in_stall, err_ovf} !== 2'b10) begin
      failures++;
      $display("FAIL stall_at6 got stall=%b ovf=%b exp stall=1 ovf=0", in_stall, err_ovf);
    end
    for (int i = 24; i < 32; i++) put(32'hABCD_0000 | 32'(i), 1'b0);
    idle(3);
    checks++;
    if (err_ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_at_full got=%b exp=0", err_ovf);
    end
    for (int i = 32; i < 40; i++) put(32'hABCD_0000 | 32'(i), 1'b0);
    idle(3);
    checks++;
    if ({in_stall, err_ovf} !== 2'b11) begin
      failures++;
      $display("FAIL ovf_after_drop got stall=%b ovf=%b exp stall=1 ovf=1", in_stall, err_ovf);
    end
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (m_axis_data !== 64'h0003_0002_0001_0000) begin
        failures++;
        $display("FAIL hold_stable got data=%h exp=0003000200010000", m_axis_data);
      end
      @(negedge aclk);
    end
    m_axis_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_data = {16'(4*k+3), 16'(4*k+2), 16'(4*k+1), 16'(4*k)};
      wait_valid(ok);
      checks++;
      if (!ok || {m_axis_data, m_axis_keep, m_axis_last} !== {exp_data, 8'hFF, 1'b0}) begin
        failures++;
        $display("FAIL drain_beat%0d got valid=%b data=%h keep=%h last=%b exp data=%h keep=ff last=0",
                 k, m_axis_valid, m_axis_data, m_axis_keep, m_axis_last, exp_data);
      end
      @(negedge aclk);
    end
    idle(3);
    checks++;
    if ({m_axis_valid, in_stall, err_ovf} !== 3'b001) begin
      failures++;
      $display("FAIL drain_empty got valid=%b stall=%b ovf=%b exp valid=0 stall=0 ovf=1",
               m_axis_valid, in_stall, err_ovf);
    end
  endtask

  task automatic test_aclken_hold;
    bit ok;
    act_calfmt   = 2'b00;
    m_axis_ready = 1'b1;
    put(32'h0000_A000, 1'b0);
    put(32'h0000_A001, 1'b0);
    aclken = 1'b0;
    put(32'h0000_DEAD, 1'b1);
    put(32'h0000_DEAD, 1'b1);
    put(32'h0000_DEAD, 1'b1);
    checks++;
    if (m_axis_valid !== 1'b0) begin
      failures++;
      $display("FAIL aclken_no_push got valid=%b exp=0", m_axis_valid);
    end
    aclken = 1'b1;
    put(32'h0000_A002, 1'b0);
    put(32'h0000_A003, 1'b0);
    idle(1);
    wait_valid(ok);
    checks++;
    if (!ok || {m_axis_data, m_axis_keep, m_axis_last} !== {64'hA003_A002_A001_A000, 8'hFF, 1'b0}) begin
      failures++;
      $display("FAIL aclken_beat got valid=%b data=%h keep=%h last=%b exp data=a003a002a001a000 keep=ff last=0",
               m_axis_valid, m_axis_data, m_axis_keep, m_axis_last);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_beat;
    bit ok;
    act_calfmt = 2'b00;
    put(32'h0000_B000, 1'b0);
    put(32'h0000_B001, 1'b0);
    idle(0);
    aresetn = 1'b0;
    @(negedge aclk);
    checks++;
    if ({m_axis_valid, m_axis_data, m_axis_keep, m_axis_last, in_stall, err_ovf, stat_sat_cnt} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got valid=%b data=%h keep=%h last=%b stall=%b ovf=%b sat=%h exp all zero",
               m_axis_valid, m_axis_data, m_axis_keep, m_axis_last, in_stall, err_ovf, stat_sat_cnt);
    end
    aresetn = 1'b1;
    idle(4);
    checks++;
    if (m_axis_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_quiet got valid=%b exp=0", m_axis_valid);
    end
    put(32'h0000_1234, 1'b1);
    idle(1);
    wait_valid(ok);
    checks++;
    if (!ok || {m_axis_data, m_axis_keep, m_axis_last} !== {64'h0000_0000_0000_1234, 8'h03, 1'b1}) begin
      failures++;
      $display("FAIL midreset_beat got valid=%b data=%h keep=%h last=%b exp data=1234 keep=03 last=1",
               m_axis_valid, m_axis_data, m_axis_keep, m_axis_last);
    end
    idle(2);
  endtask

  initial begin
    checks                = 0;
    failures              = 0;
    aresetn               = 1'b0;
    aclken                = 1'b1;
    act_calfmt            = 2'b00;
    act_cell_o_res        = '0;
    act_cell_o_info_along = '0;
    act_cell_o_vld        = 1'b0;
    m_axis_ready          = 1'b1;
    repeat (3) @(negedge aclk);
    test_reset();
    aresetn = 1'b1;
    @(negedge aclk);
    test_fp32();
    test_int32();
    test_single_latency();
    test_fmt_none();
    test_stall_overflow();
    test_aclken_hold();
    test_reset_mid_beat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
